// File: rtl/mem_stage.sv
`timescale 1ns/1ps
// mem_stage: memory-access pipeline stage between EX and WB.
//   Accepts one instruction at a time from EX and does one of three things.
//   A non-memory op is retired on the next cycle.
//   A faulting op is retired on the next cycle with wb_fault set.
//   A legal load or store issues one data-memory request and waits in WAIT
//   for dmem_ack. The access is abandoned if ACK_TIMEOUT cycles pass with no ack.
//
// Handshakes:
//   EX side : a transfer occurs on a rising edge with ex_valid && ex_ready.
//             ex_ready is high exactly while the FSM is IDLE.
//   dmem    : dmem_req is held, with all attributes stable, up to and
//             including the cycle in which dmem_ack is sampled high.
//   WB side : wb_valid is a one-cycle pulse. The wb_* bundle is meaningful
//             only while wb_valid is high.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   ex_valid/ex_ready           EX handshake
//   ex_alu_result, ex_store_data, ex_mem_read, ex_mem_write,
//   ex_funct3, ex_rd, ex_reg_write   instruction fields from EX
//   dmem_req/we/addr/wdata/be   data-memory request
//   dmem_ack, dmem_rdata        data-memory completion
//   wb_valid/data/rd/reg_write/fault   writeback bundle
//   dbg_state_o                 FSM state (0 = IDLE, 1 = WAIT)
module mem_stage #(
   parameter int unsigned ACK_TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ex_valid,
   output logic        ex_ready,
   input  logic [31:0] ex_alu_result,
   input  logic [31:0] ex_store_data,
   input  logic        ex_mem_read,
   input  logic        ex_mem_write,
   input  logic [2:0]  ex_funct3,
   input  logic [4:0]  ex_rd,
   input  logic        ex_reg_write,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_be,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        wb_valid,
   output logic [31:0] wb_data,
   output logic [4:0]  wb_rd,
   output logic        wb_reg_write,
   output logic        wb_fault,
   output logic        dbg_state_o
);

   typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [1:0]  off_q, off_d;       // byte offset captured at issue
   logic [2:0]  f3_q, f3_d;
   logic [4:0]  rd_q, rd_d;
   logic        rw_q, rw_d;
   logic        ld_q, ld_d;
   logic        req_q, req_d, we_q, we_d;
   logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
   logic [3:0]  be_q, be_d;
   logic        wbv_q, wbv_d, wbrw_q, wbrw_d, wbf_q, wbf_d;
   logic [31:0] wbd_q, wbd_d;
   logic [4:0]  wbrd_q, wbrd_d;

   logic        is_mem, fault, timeout_hit;
   logic [31:0] st_wdata, shifted, ld_data;
   logic [3:0]  st_be;

   assign ex_ready     = (state_q == S_IDLE);
   assign dbg_state_o  = state_q;
   assign dmem_req     = req_q;
   assign dmem_we      = we_q;
   assign dmem_addr    = addr_q;
   assign dmem_wdata   = wdata_q;
   assign dmem_be      = be_q;
   assign wb_valid     = wbv_q;
   assign wb_data      = wbd_q;
   assign wb_rd        = wbrd_q;
   assign wb_reg_write = wbrw_q;
   assign wb_fault     = wbf_q;

   // Timeout fires in the WAIT cycle whose count would reach ACK_TIMEOUT,
   // so dmem_req stays high for exactly ACK_TIMEOUT cycles.
   assign timeout_hit = (ACK_TIMEOUT != 0) && ((32'(cnt_q) + 32'd1) == ACK_TIMEOUT);

   always_comb begin
      is_mem = ex_mem_read | ex_mem_write;
      fault  = 1'b0;
      if (ex_mem_read && ex_mem_write)
         fault = 1'b1;
      else if (ex_mem_read)
         fault = (ex_funct3 == 3'b011) || (ex_funct3 == 3'b110) || (ex_funct3 == 3'b111);
      else if (ex_mem_write)
         fault = (ex_funct3 > 3'b010);
      if (is_mem && ex_funct3[1:0] == 2'b01 && ex_alu_result[0])
         fault = 1'b1;
      if (is_mem && ex_funct3[1:0] == 2'b10 && ex_alu_result[1:0] != 2'b00)
         fault = 1'b1;
   end

   always_comb begin
      st_be    = 4'b1111;
      st_wdata = ex_store_data;
      case (ex_funct3[1:0])
         2'b00: begin
            st_be    = 4'b0001 << ex_alu_result[1:0];
            st_wdata = {4{ex_store_data[7:0]}};
         end
         2'b01: begin
            st_be    = ex_alu_result[1] ? 4'b1100 : 4'b0011;
            st_wdata = {2{ex_store_data[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      shifted = dmem_rdata >> {off_q, 3'b000};
      case (f3_q)
         3'b000:  ld_data = {{24{shifted[7]}}, shifted[7:0]};
         3'b001:  ld_data = {{16{shifted[15]}}, shifted[15:0]};
         3'b100:  ld_data = {24'd0, shifted[7:0]};
         3'b101:  ld_data = {16'd0, shifted[15:0]};
         default: ld_data = dmem_rdata;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      off_d   = off_q;
      f3_d    = f3_q;
      rd_d    = rd_q;
      rw_d    = rw_q;
      ld_d    = ld_q;
      req_d   = req_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      wbv_d   = 1'b0;
      wbd_d   = wbd_q;
      wbrd_d  = wbrd_q;
      wbrw_d  = wbrw_q;
      wbf_d   = wbf_q;
      case (state_q)
         S_IDLE: begin
            if (ex_valid) begin
               if (!is_mem || fault) begin
                  wbv_d  = 1'b1;
                  wbd_d  = ex_alu_result;
                  wbrd_d = ex_rd;
                  wbrw_d = fault ? 1'b0 : ex_reg_write;
                  wbf_d  = fault;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = 16'd0;
                  req_d   = 1'b1;
                  we_d    = ex_mem_write;
                  addr_d  = {ex_alu_result[31:2], 2'b00};
                  be_d    = ex_mem_write ? st_be : 4'b1111;
                  wdata_d = ex_mem_write ? st_wdata : 32'd0;
                  off_d   = ex_alu_result[1:0];
                  f3_d    = ex_funct3;
                  rd_d    = ex_rd;
                  rw_d    = ex_mem_read & ex_reg_write;
                  ld_d    = ex_mem_read;
               end
            end
         end
         S_WAIT: begin
            if (dmem_ack) begin
               // An ack in the timeout cycle still retires normally.
               state_d = S_IDLE;
               req_d   = 1'b0;
               wbv_d   = 1'b1;
               wbrd_d  = rd_q;
               wbf_d   = 1'b0;
               wbd_d   = ld_q ? ld_data : 32'd0;
               wbrw_d  = ld_q ? rw_q : 1'b0;
            end else if (timeout_hit) begin
               state_d = S_IDLE;
               req_d   = 1'b0;
               wbv_d   = 1'b1;
               wbrd_d  = rd_q;
               wbd_d   = 32'd0;
               wbrw_d  = 1'b0;
               wbf_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         off_q   <= '0;
         f3_q    <= '0;
         rd_q    <= '0;
         rw_q    <= 1'b0;
         ld_q    <= 1'b0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         wbv_q   <= 1'b0;
         wbd_q   <= '0;
         wbrd_q  <= '0;
         wbrw_q  <= 1'b0;
         wbf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         off_q   <= off_d;
         f3_q    <= f3_d;
         rd_q    <= rd_d;
         rw_q    <= rw_d;
         ld_q    <= ld_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         wbv_q   <= wbv_d;
         wbd_q   <= wbd_d;
         wbrd_q  <= wbrd_d;
         wbrw_q  <= wbrw_d;
         wbf_q   <= wbf_d;
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
`timescale 1ns/1ps
module tb_mem_stage;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic        ex_valid, ex_ready, ex_mem_read, ex_mem_write, ex_reg_write;
   logic [31:0] ex_alu_result, ex_store_data;
   logic [2:0]  ex_funct3;
   logic [4:0]  ex_rd;
   logic        dmem_req, dmem_we, dmem_ack;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  dmem_be;
   logic        wb_valid, wb_reg_write, wb_fault, dbg_state;
   logic [31:0] wb_data;
   logic [4:0]  wb_rd;

   mem_stage #(.ACK_TIMEOUT(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .ex_valid(ex_valid), .ex_ready(ex_ready),
      .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
      .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
      .ex_funct3(ex_funct3), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
      .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd),
      .wb_reg_write(wb_reg_write), .wb_fault(wb_fault),
      .dbg_state_o(dbg_state)
   );

   // ---------------- scoreboard ----------------
   // Entry: {data_dont_care, fault, reg_write, rd[4:0], data[31:0]}
   logic [39:0] exp_q[$];
   logic [39:0] mon_e;
   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input logic dc, input logic flt, input logic rw,
                       input logic [4:0] rd, input logic [31:0] data);
      exp_q.push_back({dc, flt, rw, rd, data});
   endtask

   always @(negedge clk) begin
      if (rst_n === 1'b1 && wb_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL wb_unexpected: got wb_valid=1 data %h, expected no retirement at %0t",
                     wb_data, $time);
         end else begin
            mon_e = exp_q.pop_front();
            chk("wb_fault", {31'd0, wb_fault}, {31'd0, mon_e[38]});
            chk("wb_reg_write", {31'd0, wb_reg_write}, {31'd0, mon_e[37]});
            if (!mon_e[39]) begin
               chk("wb_rd", {27'd0, wb_rd}, {27'd0, mon_e[36:32]});
               chk("wb_data", wb_data, mon_e[31:0]);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Called at a falling edge with the stage idle; returns at the falling
   // edge after the accepting rising edge.
   task automatic send(input logic [31:0] alu, input logic [31:0] sd, input logic [2:0] f3,
                       input logic mr, input logic mw, input logic [4:0] rd, input logic rw);
      chk("ex_ready_before_send", {31'd0, ex_ready}, 32'd1);
      ex_valid = 1'b1; ex_alu_result = alu; ex_store_data = sd; ex_funct3 = f3;
      ex_mem_read = mr; ex_mem_write = mw; ex_rd = rd; ex_reg_write = rw;
      @(negedge clk);
      ex_valid = 1'b0; ex_alu_result = '0; ex_store_data = '0; ex_funct3 = '0;
      ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_rd = '0; ex_reg_write = 1'b0;
   endtask

   // Holds n WAIT cycles, checking request stability; acks in the n-th when do_ack.
   task automatic wait_ack(input int n, input logic [31:0] rdata, input logic [31:0] e_addr,
                           input logic [31:0] e_wdata, input logic [3:0] e_be,
                           input logic e_we, input logic do_ack);
      for (int i = 1; i <= n; i++) begin
         chk("dmem_req_wait", {31'd0, dmem_req}, 32'd1);
         chk("ex_ready_wait", {31'd0, ex_ready}, 32'd0);
         chk("dbg_state_wait", {31'd0, dbg_state}, 32'd1);
         chk("dmem_addr", dmem_addr, e_addr);
         chk("dmem_wdata", dmem_wdata, e_wdata);
         chk("dmem_be", {28'd0, dmem_be}, {28'd0, e_be});
         chk("dmem_we", {31'd0, dmem_we}, {31'd0, e_we});
         if (i == n && do_ack) begin
            dmem_ack = 1'b1;
            dmem_rdata = rdata;
         end
         @(negedge clk);
         dmem_ack = 1'b0;
         dmem_rdata = '0;
      end
      chk("dmem_req_after", {31'd0, dmem_req}, 32'd0);
      chk("ex_ready_after", {31'd0, ex_ready}, 32'd1);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_req"}, {31'd0, dmem_req}, 32'd0);
      chk({tag, "_we"}, {31'd0, dmem_we}, 32'd0);
      chk({tag, "_addr"}, dmem_addr, 32'd0);
      chk({tag, "_wdata"}, dmem_wdata, 32'd0);
      chk({tag, "_be"}, {28'd0, dmem_be}, 32'd0);
      chk({tag, "_wbv"}, {31'd0, wb_valid}, 32'd0);
      chk({tag, "_wbd"}, wb_data, 32'd0);
      chk({tag, "_wbrd"}, {27'd0, wb_rd}, 32'd0);
      chk({tag, "_wbrw"}, {31'd0, wb_reg_write}, 32'd0);
      chk({tag, "_wbf"}, {31'd0, wb_fault}, 32'd0);
      chk({tag, "_ready"}, {31'd0, ex_ready}, 32'd1);
      chk({tag, "_state"}, {31'd0, dbg_state}, 32'd0);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog: got no completion, expected finish before 200000ns");
      $fatal(1, "watchdog expired");
   end

   // ---------------- stimulus ----------------
   initial begin
      rst_n = 1'b0;
      ex_valid = 1'b0; ex_alu_result = '0; ex_store_data = '0; ex_funct3 = '0;
      ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_rd = '0; ex_reg_write = 1'b0;
      dmem_ack = 1'b0; dmem_rdata = '0;
      @(negedge clk);
      @(negedge clk);
      chk_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // ADD result, rd=5
      push(0, 0, 1, 5'd5, 32'h0000_1234);
      send(32'h0000_1234, 32'd0, 3'b000, 0, 0, 5'd5, 1);
      chk("add_no_req", {31'd0, dmem_req}, 32'd0);

      // back-to-back non-memory ops
      push(0, 0, 0, 5'd9, 32'hCAFE_0000);
      push(0, 0, 1, 5'd31, 32'hFFFF_FFFF);
      send(32'hCAFE_0000, 32'd0, 3'b000, 0, 0, 5'd9, 0);
      send(32'hFFFF_FFFF, 32'd0, 3'b000, 0, 0, 5'd31, 1);
      chk("b2b_no_req", {31'd0, dmem_req}, 32'd0);

      // LB / LBU addr 0x103, ack in 3rd WAIT cycle
      push(0, 0, 1, 5'd7, 32'hFFFF_FF80);
      send(32'h103, 32'd0, 3'b000, 1, 0, 5'd7, 1);
      wait_ack(3, 32'h80AA_BBCC, 32'h100, 32'd0, 4'b1111, 0, 1);
      push(0, 0, 1, 5'd7, 32'h0000_0080);
      send(32'h103, 32'd0, 3'b100, 1, 0, 5'd7, 1);
      wait_ack(3, 32'h80AA_BBCC, 32'h100, 32'd0, 4'b1111, 0, 1);

      // stores
      push(0, 0, 0, 5'd3, 32'd0);
      send(32'h202, 32'h1234_ABCD, 3'b001, 0, 1, 5'd3, 1);
      wait_ack(2, 32'hFFFF_FFFF, 32'h200, 32'hABCD_ABCD, 4'b1100, 1, 1);
      push(0, 0, 0, 5'd0, 32'd0);
      send(32'h301, 32'h1234_5655, 3'b000, 0, 1, 5'd0, 0);
      wait_ack(1, 32'd0, 32'h300, 32'h5555_5555, 4'b0010, 1, 1);
      push(0, 0, 0, 5'd2, 32'd0);
      send(32'h40, 32'hA5A5_0F0F, 3'b010, 0, 1, 5'd2, 0);
      wait_ack(1, 32'd0, 32'h40, 32'hA5A5_0F0F, 4'b1111, 1, 1);

      // LH / LHU / LW
      push(0, 0, 1, 5'd10, 32'hFFFF_8001);
      send(32'h102, 32'd0, 3'b001, 1, 0, 5'd10, 1);
      wait_ack(1, 32'h8001_7FFF, 32'h100, 32'd0, 4'b1111, 0, 1);
      push(0, 0, 1, 5'd11, 32'h0000_8001);
      send(32'h102, 32'd0, 3'b101, 1, 0, 5'd11, 1);
      wait_ack(2, 32'h8001_7FFF, 32'h100, 32'd0, 4'b1111, 0, 1);
      push(0, 0, 0, 5'd12, 32'hDEAD_BEEF);
      send(32'h104, 32'd0, 3'b010, 1, 0, 5'd12, 0);
      wait_ack(1, 32'hDEAD_BEEF, 32'h104, 32'd0, 4'b1111, 0, 1);

      // faulting ops: no request, retire next cycle with fault
      push(0, 1, 0, 5'd4, 32'h102);
      send(32'h102, 32'd0, 3'b010, 1, 0, 5'd4, 1);
      chk("lw_mis_no_req", {31'd0, dmem_req}, 32'd0);
      push(0, 1, 0, 5'd6, 32'h101);
      send(32'h101, 32'd0, 3'b001, 1, 0, 5'd6, 1);
      chk("lh_mis_no_req", {31'd0, dmem_req}, 32'd0);
      push(0, 1, 0, 5'd1, 32'h10);
      send(32'h10, 32'h55, 3'b011, 0, 1, 5'd1, 1);
      chk("st_f3_no_req", {31'd0, dmem_req}, 32'd0);
      push(0, 1, 0, 5'd13, 32'h20);
      send(32'h20, 32'd0, 3'b010, 1, 1, 5'd13, 1);
      chk("rw_both_no_req", {31'd0, dmem_req}, 32'd0);
      push(0, 1, 0, 5'd14, 32'h30);
      send(32'h30, 32'd0, 3'b111, 1, 0, 5'd14, 1);
      chk("ld_f3_no_req", {31'd0, dmem_req}, 32'd0);

      // timeout: 4 WAIT cycles with no ack, then faulting retirement
      push(1, 1, 0, 5'd8, 32'd0);
      send(32'h400, 32'd0, 3'b010, 1, 0, 5'd8, 1);
      wait_ack(4, 32'd0, 32'h400, 32'd0, 4'b1111, 0, 0);
      // ack in the timeout cycle wins
      push(0, 0, 1, 5'd8, 32'h600D_F00D);
      send(32'h400, 32'd0, 3'b010, 1, 0, 5'd8, 1);
      wait_ack(4, 32'h600D_F00D, 32'h400, 32'd0, 4'b1111, 0, 1);

      // reset in WAIT, then a stale ack after release
      send(32'h500, 32'd0, 3'b010, 1, 0, 5'd15, 1);
      chk("pre_reset_req", {31'd0, dmem_req}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk_zero("async_rst");
      @(negedge clk);
      rst_n = 1'b1;
      dmem_ack = 1'b1;
      dmem_rdata = 32'h1111_2222;
      @(negedge clk);
      dmem_ack = 1'b0;
      dmem_rdata = '0;
      chk_zero("stale_ack");
      @(negedge clk);
      chk_zero("stale_ack2");
      @(negedge clk);

      chk("scoreboard_empty", exp_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
